lfsr_rng_arbiter: RTL and testbench

Shares one 8-bit Fibonacci LFSR random source among NREQ requesters. Each grant delivers a fresh byte produced by STEPS shift cycles. The block also owns seeding: it substitutes a non-zero default for an all-zero seed and holds requests off until a seed has been loaded. It sits between the random-number consumers and contains the LFSR datapath (feedback d[7]^d[5]^d[4]^d[2], shift left, feedback into bit 0).

---
 rtl/lfsr_rng_arbiter_if.sv | 38 +++
 rtl/lfsr_rng_arbiter.sv | 119 +++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_rng_arbiter_if.sv
// ---------------------------------------------------------------------------
// lfsr_rng_arbiter_if
//   Bundle between the random-number consumers (master) and the shared
//   LFSR arbiter (slave).
//
//   seed_load  master->slave  single-cycle pulse, load seed
//   seed       master->slave  seed value, sampled with seed_load
//   req        master->slave  level requests, one bit per requester
//   seed_ready slave->master  seed_load is accepted only while high
//   seeded     slave->master  a seed has been loaded since reset
//   gnt        slave->master  one-hot, high for the response cycle only
//   rnd_valid  slave->master  qualifies rnd_data
//   rnd_data   slave->master  current LFSR state
//   busy       slave->master  a grant is in flight
// ---------------------------------------------------------------------------
interface lfsr_rng_arbiter_if #(
    parameter int NREQ = 4
);
    logic            seed_load;
    logic [7:0]      seed;
    logic [NREQ-1:0] req;
    logic            seed_ready;
    logic            seeded;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [7:0]      rnd_data;
    logic            busy;

    modport master (
        output seed_load, seed, req,
        input  seed_ready, seeded, gnt, rnd_valid, rnd_data, busy
    );

    modport slave (
        input  seed_load, seed, req,
        output seed_ready, seeded, gnt, rnd_valid, rnd_data, busy
    );
endinterface

// File: rtl/lfsr_rng_arbiter.sv
// ---------------------------------------------------------------------------
// lfsr_rng_arbiter
//   One 8-bit Fibonacci LFSR (taps 7,5,4,2, shift left, feedback into bit 0)
//   shared round-robin among NREQ requesters. Each grant runs STEPS shifts
//   and then presents the resulting byte for one cycle with gnt/rnd_valid.
//   Requests are held off until a seed is loaded; a zero seed is replaced
//   by DEFAULT_SEED so the LFSR can never sit in the all-zero state.
//
//   clk   clock, all state changes on posedge
//   rst   asynchronous, active-high reset
//   bus   lfsr_rng_arbiter_if slave modport (seed, requests, grant, data)
// ---------------------------------------------------------------------------
module lfsr_rng_arbiter #(
    parameter int         NREQ         = 4,
    parameter int         STEPS        = 8,
    parameter logic [7:0] DEFAULT_SEED = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_rng_arbiter_if.slave  bus
);

    localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] CNT_LAST = 4'(STEPS - 1);

    typedef enum logic [1:0] {
        S_UNSEEDED = 2'd0,
        S_IDLE     = 2'd1,
        S_SHIFT    = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t          state_q;
    logic [7:0]      lfsr_q;
    logic [3:0]      cnt_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win_q;
    logic            seeded_q;

    logic [PW-1:0]   win_d;
    logic            found;
    logic [7:0]      seed_val;
    logic            fb;

    // Zero seed would lock the LFSR at zero forever; substitute the default.
    assign seed_val = (bus.seed == 8'h00) ? DEFAULT_SEED : bus.seed;
    assign fb       = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[2];

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        win_d = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req[(int'(ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                win_d = PW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_UNSEEDED;
            lfsr_q   <= 8'h00;
            cnt_q    <= 4'd0;
            ptr_q    <= '0;
            win_q    <= '0;
            seeded_q <= 1'b0;
        end else begin
            case (state_q)
                S_UNSEEDED: begin
                    if (bus.seed_load) begin
                        lfsr_q   <= seed_val;
                        seeded_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    // Reseed wins over a request; the request simply waits.
                    if (bus.seed_load) begin
                        lfsr_q <= seed_val;
                    end else if (found) begin
                        win_q   <= win_d;
                        cnt_q   <= 4'd0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    lfsr_q <= {lfsr_q[6:0], fb};
                    cnt_q  <= cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    ptr_q   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_UNSEEDED;
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so an async reset
    // clears them in the same instant.
    always_comb begin
        bus.gnt = '0;
        if (state_q == S_RESP) begin
            bus.gnt[win_q] = 1'b1;
        end
    end

    assign bus.rnd_valid  = (state_q == S_RESP);
    assign bus.busy       = (state_q == S_SHIFT) || (state_q == S_RESP);
    assign bus.seed_ready = (state_q == S_UNSEEDED) || (state_q == S_IDLE);
    assign bus.seeded     = seeded_q;
    assign bus.rnd_data   = lfsr_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
module tb_lfsr_rng_arbiter;
    localparam int NREQ  = 4;
    localparam int STEPS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_rng_arbiter_if #(.NREQ(NREQ)) bus ();

    lfsr_rng_arbiter #(.NREQ(NREQ), .STEPS(STEPS), .DEFAULT_SEED(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic logic [7:0] adv(input logic [7:0] s, input int n);
        logic [7:0] r = s;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[2]};
        return r;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    // m_el < 0: no grant in flight; otherwise number of shifts already done.
    int         m_el     = -1;
    bit         m_seeded = 0;
    logic [7:0] m_base   = 8'h00;
    int         m_ptr    = 0;
    int         m_win    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_el = -1; m_seeded = 0; m_base = 8'h00; m_ptr = 0; m_win = 0;
        end else if (m_el < 0) begin
            if (bus.seed_load) begin
                m_base   = (bus.seed == 8'h00) ? 8'hA5 : bus.seed;
                m_seeded = 1;
            end else if (m_seeded && bus.req != 0) begin
                for (int k = NREQ - 1; k >= 0; k--)
                    if (bus.req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
                m_el = 0;
            end
        end else if (m_el < STEPS) begin
            m_el++;
        end else begin
            m_base = adv(m_base, STEPS);
            m_ptr  = (m_win + 1) % NREQ;
            m_el   = -1;
        end
    end

    always @(negedge clk) begin
        logic e_busy, e_valid;
        logic [NREQ-1:0] e_gnt;
        logic [7:0] e_data;
        e_busy  = (m_el >= 0);
        e_valid = (m_el == STEPS);
        e_gnt   = e_valid ? NREQ'(1 << m_win) : '0;
        e_data  = e_busy ? adv(m_base, m_el) : m_base;
        chk("m_gnt",        32'(bus.gnt),        32'(e_gnt));
        chk("m_rnd_valid",  32'(bus.rnd_valid),  32'(e_valid));
        chk("m_busy",       32'(bus.busy),       32'(e_busy));
        chk("m_seed_ready", 32'(bus.seed_ready), 32'(!e_busy));
        chk("m_seeded",     32'(bus.seeded),     32'(m_seeded));
        chk("m_rnd_data",   32'(bus.rnd_data),   32'(e_data));
    end

    // ---------------- grant monitor / requester behaviour ----------------
    logic [NREQ-1:0] last_gnt = '0;
    int cyc = 0;
    int gq[$];
    int tq[$];
    logic [7:0] dq[$];

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        last_gnt = bus.gnt;
        if (bus.gnt != 0) begin
            for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) gq.push_back(i);
            tq.push_back(cyc);
            dq.push_back(bus.rnd_data);
        end
    end

    // Inputs change 1 time unit after the edge; granted requests drop then.
    task automatic step();
        @(posedge clk);
        #1;
        bus.seed_load = 1'b0;
        bus.req       = bus.req & ~last_gnt;
    endtask

    task automatic wait_q(input int n, input int lim);
        int c = 0;
        while (gq.size() < n && c < lim) begin step(); c++; end
        chk("wait_grant_timeout", 32'(gq.size() >= n), 32'd1);
    endtask

    task automatic load_seed(input logic [7:0] s);
        bus.seed_load = 1'b1;
        bus.seed      = s;
        step();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [7:0] exp_seq [8];

    initial begin
        bus.seed_load = 1'b0;
        bus.seed      = 8'h00;
        bus.req       = '0;
        exp_seq = '{8'h02, 8'h04, 8'h09, 8'h12, 8'h25, 8'h4A, 8'h94, 8'h29};

        repeat (3) step();
        rst = 1'b0;
        chk("rst_seed_ready", 32'(bus.seed_ready), 32'd1);
        chk("rst_seeded",     32'(bus.seeded),     32'd0);
        chk("rst_rnd_data",   32'(bus.rnd_data),   32'h00);
        chk("rst_busy",       32'(bus.busy),       32'd0);

        // Unseeded: requests ignored
        begin
            int bad = 0;
            bus.req = 4'b0001;
            repeat (20) begin
                step();
                if (bus.gnt != 0 || bus.busy) bad++;
            end
            chk("unseeded_no_grant", 32'(bad), 32'd0);
            chk("unseeded_seeded",   32'(bus.seeded), 32'd0);
            bus.req = '0;
        end

        // Single grant from seed 01
        load_seed(8'h01);
        chk("seed01_data",   32'(bus.rnd_data), 32'h01);
        chk("seed01_seeded", 32'(bus.seeded),   32'd1);
        bus.req = 4'b0001;
        step();
        chk("e0_busy", 32'(bus.busy), 32'd1);
        for (int k = 0; k < STEPS; k++) begin
            step();
            chk($sformatf("shift_%0d", k + 1), 32'(bus.rnd_data), 32'(exp_seq[k]));
            if (k < STEPS - 1) chk("early_gnt", 32'(bus.gnt), 32'd0);
        end
        chk("single_gnt",   32'(bus.gnt),       32'b0001);
        chk("single_valid", 32'(bus.rnd_valid), 32'd1);
        step();
        chk("single_idle_busy", 32'(bus.busy), 32'd0);
        chk("single_req_drop",  32'(bus.req),  32'd0);

        // Zero seed substitution
        load_seed(8'h00);
        chk("zero_seed_data",   32'(bus.rnd_data), 32'hA5);
        chk("zero_seed_seeded", 32'(bus.seeded),   32'd1);

        // Round robin from a fresh pointer
        do_reset();
        load_seed(8'h5C);
        gq.delete(); tq.delete(); dq.delete();
        bus.req = 4'b1111;
        wait_q(4, 60);
        if (gq.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", 32'(gq[i]), 32'(i));
            for (int i = 1; i < 4; i++) chk("rr_spacing", 32'(tq[i] - tq[i-1]), 32'(STEPS + 2));
        end
        step();
        gq.delete(); tq.delete(); dq.delete();
        bus.req = 4'b0011;
        wait_q(1, 20);
        if (gq.size() >= 1) chk("rr_wrap", 32'(gq[0]), 32'd0);
        repeat (12) step();
        bus.req = '0;
        repeat (2) step();

        // seed_load during SHIFT is ignored
        load_seed(8'h01);
        gq.delete(); tq.delete(); dq.delete();
        bus.req = 4'b0001;
        step();
        repeat (3) step();
        bus.seed_load = 1'b1;
        bus.seed      = 8'h77;
        step();
        wait_q(1, 20);
        if (dq.size() >= 1) chk("seed_in_shift_byte", 32'(dq[0]), 32'h29);
        repeat (2) step();

        // seed_load and req together: reseed first, grant one cycle later
        gq.delete(); tq.delete(); dq.delete();
        bus.seed_load = 1'b1;
        bus.seed      = 8'h01;
        bus.req       = 4'b0010;
        step();
        chk("collide_not_busy", 32'(bus.busy),     32'd0);
        chk("collide_data",     32'(bus.rnd_data), 32'h01);
        step();
        chk("collide_busy_next", 32'(bus.busy), 32'd1);
        wait_q(1, 20);
        if (dq.size() >= 1) chk("collide_byte", 32'(dq[0]), 32'h29);
        if (gq.size() >= 1) chk("collide_who",  32'(gq[0]), 32'd1);
        repeat (2) step();

        // Reset in the middle of SHIFT
        load_seed(8'h01);
        bus.req = 4'b0001;
        step();
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_gnt",        32'(bus.gnt),        32'd0);
        chk("midrst_valid",      32'(bus.rnd_valid),  32'd0);
        chk("midrst_busy",       32'(bus.busy),       32'd0);
        chk("midrst_data",       32'(bus.rnd_data),   32'h00);
        chk("midrst_seeded",     32'(bus.seeded),     32'd0);
        chk("midrst_seed_ready", 32'(bus.seed_ready), 32'd1);
        step();
        rst = 1'b0;
        bus.req = '0;
        step();

        // Randomised traffic against the model
        load_seed(8'($urandom));
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 30) == 0) begin
                bus.seed_load = 1'b1;
                bus.seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) bus.req = bus.req | NREQ'($urandom);
            if ($urandom_range(0, 40) == 0) bus.req = bus.req & NREQ'($urandom);
            if (k == 1500) begin
                #2 rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        bus.req = '0;
        repeat (15) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
